// File: rtl/ring_osc_ctrl.sv
// Ring-oscillator frequency meter: enables the inverter chain, lets it settle,
// then counts synchronized ro_in rising edges over a fixed gate window.
module ring_osc_ctrl #(
  parameter int GATE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ro_in,
  output logic                 ro_en,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overflow
);

  localparam int MAX_PH = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int PH_W   = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
  localparam logic [PH_W-1:0]      SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0]      GATE_LAST   = PH_W'(GATE_CYCLES - 1);
  localparam logic [PH_W-1:0]      PH_ONE      = PH_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, GATE, DONE} state_t;

  state_t               state, state_nxt;
  logic [PH_W-1:0]      ph, ph_nxt;
  logic                 sync_p0, sync_p1, prev_p2;
  logic                 pulse_p2;
  logic [CNT_WIDTH-1:0] edge_cnt, edge_cnt_nxt;
  logic                 sat, sat_nxt;
  logic                 load;

  // Returns {sat, count}; the counter sticks at all-ones and flags the lost edge.
  function automatic logic [CNT_WIDTH:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                 input logic sat_in);
    if (cnt == CNT_MAX) return {1'b1, cnt};
    return {sat_in, cnt + CNT_ONE};
  endfunction

  // Stage p0/p1: two-flop synchronizer; stage p2: rising-edge detector
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= ro_in;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign pulse_p2 = sync_p1 & ~prev_p2;

  always_comb begin
    state_nxt    = state;
    ph_nxt       = ph;
    edge_cnt_nxt = edge_cnt;
    sat_nxt      = sat;
    load         = 1'b0;
    ro_en        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETTLE;
          ph_nxt    = '0;
        end
      end
      SETTLE: begin
        ro_en        = 1'b1;
        busy         = 1'b1;
        edge_cnt_nxt = '0;
        sat_nxt      = 1'b0;
        if (ph == SETTLE_LAST) begin
          state_nxt = GATE;
          ph_nxt    = '0;
        end else begin
          ph_nxt = ph + PH_ONE;
        end
      end
      GATE: begin
        ro_en = 1'b1;
        busy  = 1'b1;
        if (pulse_p2) {sat_nxt, edge_cnt_nxt} = sat_inc(edge_cnt, sat);
        // Result registers load on the way into DONE so they are valid with done.
        if (ph == GATE_LAST) begin
          state_nxt = DONE;
          ph_nxt    = '0;
          load      = 1'b1;
        end else begin
          ph_nxt = ph + PH_ONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ph       <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      ph       <= ph_nxt;
      edge_cnt <= edge_cnt_nxt;
      sat      <= sat_nxt;
      if (load) begin
        count    <= edge_cnt_nxt;
        overflow <= sat_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ring_osc_ctrl.sv
// Self-checking bench for ring_osc_ctrl: a 16-bit and a 4-bit counter instance
// share one ro_in generator; results are scoreboarded against queued expectations.
module tb_ring_osc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic        ro_in = 1'b0;
  logic        ro_en_a, busy_a, done_a, overflow_a;
  logic        ro_en_b, busy_b, done_b, overflow_b;
  logic [15:0] count_a;
  logic [3:0]  count_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] cnt;
    logic        ovf;
  } res_t;

  res_t q_a[$];
  res_t q_b[$];

  typedef struct {
    int          period;
    bit          level;
    bit          sel;
    logic [15:0] cnt;
    bit          ovf;
  } vec_t;

  vec_t        vecs[7];
  logic [15:0] last_cnt[2];
  bit          last_ovf[2];

  int ro_period = 0;
  bit ro_level  = 1'b0;
  int ro_ph     = 0;

  ring_osc_ctrl #(.GATE_CYCLES(64), .SETTLE_CYCLES(4), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .ro_in(ro_in),
    .ro_en(ro_en_a), .busy(busy_a), .done(done_a),
    .count(count_a), .overflow(overflow_a)
  );

  ring_osc_ctrl #(.GATE_CYCLES(64), .SETTLE_CYCLES(4), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .ro_in(ro_in),
    .ro_en(ro_en_b), .busy(busy_b), .done(done_b),
    .count(count_b), .overflow(overflow_b)
  );

  always #5 clk = ~clk;

  // Square wave of ro_period clk cycles (half high, half low), or a constant level.
  always @(negedge clk) begin
    if (ro_period == 0) begin
      ro_in = ro_level;
    end else begin
      ro_ph = (ro_ph + 1) % ro_period;
      ro_in = (ro_ph < ro_period / 2);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    res_t r;
    if (done_a === 1'b1) begin
      chk("sb_a_pending", 32'(q_a.size() > 0), 1);
      if (q_a.size() > 0) begin
        r = q_a.pop_front();
        chk("sb_a_count", count_a, r.cnt);
        chk("sb_a_overflow", overflow_a, r.ovf);
      end
    end
    if (done_b === 1'b1) begin
      chk("sb_b_pending", 32'(q_b.size() > 0), 1);
      if (q_b.size() > 0) begin
        r = q_b.pop_front();
        chk("sb_b_count", 32'(count_b), r.cnt);
        chk("sb_b_overflow", overflow_b, r.ovf);
      end
    end
  end

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  // Called at a negedge: raises start now, then checks the per-cycle profile.
  // nruns>1 holds start high for back-to-back runs; re1/re2 re-pulse start mid-run.
  task automatic run(input bit sel, input int nruns, input int re1, input int re2,
                     input logic [15:0] ecnt, input bit eovf);
    res_t        r;
    int          p, ridx;
    bit          e_en, e_busy, e_done;
    logic        s_en, s_busy, s_done, s_ovf;
    logic [15:0] s_cnt, held;
    r.cnt = ecnt;
    r.ovf = eovf;
    for (int i = 0; i < nruns; i++) begin
      if (sel) q_b.push_back(r);
      else     q_a.push_back(r);
    end
    set_start(sel, 1'b1);
    for (int off = 1; off <= 70 * nruns + 3; off++) begin
      @(negedge clk);
      s_en   = sel ? ro_en_b : ro_en_a;
      s_busy = sel ? busy_b  : busy_a;
      s_done = sel ? done_b  : done_a;
      s_cnt  = sel ? {12'd0, count_b} : count_a;
      s_ovf  = sel ? overflow_b : overflow_a;
      p = 0;
      if (off <= 70 * nruns) p = (off - 1) % 70 + 1;
      e_en   = (p >= 1) && (p <= 68);
      e_busy = (p >= 1) && (p <= 69);
      e_done = (p == 69);
      chk($sformatf("ro_en_%0d_off%0d", sel, off), s_en, e_en);
      chk($sformatf("busy_%0d_off%0d", sel, off), s_busy, e_busy);
      chk($sformatf("done_%0d_off%0d", sel, off), s_done, e_done);
      if (p == 30) begin
        ridx = (off - 1) / 70;
        held = (ridx == 0) ? last_cnt[sel] : ecnt;
        chk($sformatf("count_hold_%0d_off%0d", sel, off), s_cnt, held);
        chk($sformatf("ovf_hold_%0d_off%0d", sel, off), s_ovf, (ridx == 0) ? last_ovf[sel] : eovf);
      end
      set_start(sel, (off <= 70 * (nruns - 1)) || (off == re1) || (off == re2));
    end
    last_cnt[sel] = ecnt;
    last_ovf[sel] = eovf;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8,  1'b0, 1'b0, 16'd8,  1'b0};
    vecs[1] = '{0,  1'b0, 1'b0, 16'd0,  1'b0};
    vecs[2] = '{0,  1'b1, 1'b0, 16'd0,  1'b0};
    vecs[3] = '{16, 1'b0, 1'b0, 16'd4,  1'b0};
    vecs[4] = '{4,  1'b0, 1'b0, 16'd16, 1'b0};
    vecs[5] = '{4,  1'b0, 1'b1, 16'd15, 1'b1};
    vecs[6] = '{8,  1'b0, 1'b1, 16'd8,  1'b0};
    last_cnt[0] = '0;
    last_cnt[1] = '0;
    last_ovf[0] = 1'b0;
    last_ovf[1] = 1'b0;

    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ro_en_a", ro_en_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_count_a", count_a, 0);
    chk("rst_overflow_a", overflow_a, 0);
    chk("rst_ro_en_b", ro_en_b, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_count_b", 32'(count_b), 0);
    chk("rst_overflow_b", overflow_b, 0);

    // Release reset and request a run in the same cycle.
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ro_period = vecs[i].period;
      ro_level  = vecs[i].level;
      run(vecs[i].sel, 1, -1, -1, vecs[i].cnt, vecs[i].ovf);
    end

    // start re-pulsed mid-run is ignored.
    ro_period = 8;
    ro_level  = 1'b0;
    run(1'b0, 1, 10, 40, 16'd8, 1'b0);

    // Reset mid-GATE aborts the run without a done pulse and clears the result.
    start_a = 1'b1;
    for (int off = 1; off <= 80; off++) begin
      @(negedge clk);
      if (off <= 29) chk($sformatf("abort_busy_off%0d", off), busy_a, 1);
      if (off == 31) begin
        chk("abort_busy", busy_a, 0);
        chk("abort_ro_en", ro_en_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_count", count_a, 0);
        chk("abort_overflow", overflow_a, 0);
        chk("abort_count_b", 32'(count_b), 0);
        rst = 1'b0;
      end
      if (off >= 32) begin
        chk($sformatf("abort_nodone_off%0d", off), done_a, 0);
        chk($sformatf("abort_idle_off%0d", off), busy_a, 0);
      end
      if (off == 1)  start_a = 1'b0;
      if (off == 30) rst = 1'b1;
    end
    last_cnt[0] = '0;
    last_cnt[1] = '0;
    last_ovf[0] = 1'b0;
    last_ovf[1] = 1'b0;
    run(1'b0, 1, -1, -1, 16'd8, 1'b0);

    // start held high: three back-to-back runs, one IDLE cycle between them.
    run(1'b0, 3, -1, -1, 16'd8, 1'b0);

    chk("sb_a_drained", q_a.size(), 0);
    chk("sb_b_drained", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
